qed_mode_ctrl: RTL and testbench

- Upstream controller for the QED instruction queue. Generates `exec_dup` and fetch hold, so the design alternates between original bursts and duplicate bursts.
- Keeps a shadow occupancy count that mirrors the queue's insert/delete rules exactly.
- Cross-checks the queue's `vld_out` every cycle and flags any divergence.
- Sits between the fetch unit and the QED instruction queue.

---
 rtl/qed_mode_ctrl_if.sv | 42 ++++
 rtl/qed_mode_ctrl.sv | 132 +++++++++++++
 tb/tb_qed_mode_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/qed_mode_ctrl_if.sv
// Connects the QED mode controller to the fetch unit and the QED queue.
// Port summary:
//   qed_ena, IF_stall, ifu_qed_instruction, qic_vld  : into the controller
//   exec_dup, ifu_hold, occ_cnt, qed_ready, sync_err  : out of the controller
// Modports: master = controller side, slave = fetch/queue (environment) side.
interface qed_mode_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    logic             qed_ena;
    logic             IF_stall;
    logic [31:0]      ifu_qed_instruction;
    logic             qic_vld;
    logic             exec_dup;
    logic             ifu_hold;
    logic [CNT_W-1:0] occ_cnt;
    logic             qed_ready;
    logic             sync_err;

    modport master (
        input  qed_ena,
        input  IF_stall,
        input  ifu_qed_instruction,
        input  qic_vld,
        output exec_dup,
        output ifu_hold,
        output occ_cnt,
        output qed_ready,
        output sync_err
    );

    modport slave (
        output qed_ena,
        output IF_stall,
        output ifu_qed_instruction,
        output qic_vld,
        input  exec_dup,
        input  ifu_hold,
        input  occ_cnt,
        input  qed_ready,
        input  sync_err
    );
endinterface

// File: rtl/qed_mode_ctrl.sv
// QED mode controller: alternates the QED instruction queue between original
// bursts (fetch inserts) and duplicate bursts (queue replays, fetch held),
// keeps a shadow occupancy count of the queue and flags any divergence
// between the shadow's insert/delete and the queue's vld_out.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset
//   bus   : qed_mode_ctrl_if.master (qed_ena, IF_stall, ifu_qed_instruction,
//           qic_vld in; exec_dup, ifu_hold, occ_cnt, qed_ready, sync_err out)
module qed_mode_ctrl #(
    parameter int unsigned ICACHESIZE = 32,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic           clk,
    input  logic           rst,
    qed_mode_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] OCC_FULL   = CNT_W'(ICACHESIZE - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ORIG = 2'd1,
        DUP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             exec_dup_q, exec_dup_d;
    logic             qed_ready_q, qed_ready_d;
    logic             sync_err_q, sync_err_d;

    logic             nop;
    logic             ins;
    logic             del;

    // Only the opcode field identifies a nop; upper bits are don't-care here.
    logic [24:0]      unused_instr_hi;
    assign unused_instr_hi = bus.ifu_qed_instruction[31:7];

    // Next-state, shadow counters and registered-output targets.
    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        burst_d     = burst_q;
        sync_err_d  = sync_err_q;

        nop = (bus.ifu_qed_instruction[6:0] == 7'b1111111);
        ins = (state_q == ORIG) && !bus.IF_stall && !nop && (occ_q != OCC_FULL);
        del = (state_q == DUP) && !bus.IF_stall && (occ_q != CNT_ZERO);

        if (ins) begin
            occ_d   = occ_q + CNT_ONE;
            burst_d = burst_q + CNT_ONE;
        end else if (del) begin
            occ_d   = occ_q - CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (bus.qed_ena) begin
                    state_d = ORIG;
                    burst_d = CNT_ZERO;
                end
            end
            ORIG: begin
                // Burst limit, queue full, or a drain request with work pending.
                if ((ins && (burst_q == BURST_LAST)) ||
                    (occ_d == OCC_FULL) ||
                    (!bus.qed_ena && (occ_d != CNT_ZERO))) begin
                    state_d = DUP;
                end else if (!bus.qed_ena) begin
                    state_d = IDLE;
                end
            end
            DUP: begin
                // A duplicate burst always drains fully before leaving.
                if (occ_d == CNT_ZERO) begin
                    if (bus.qed_ena) begin
                        state_d = ORIG;
                        burst_d = CNT_ZERO;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registering from next values gives the same timing as decoding the
        // current registered state and count.
        exec_dup_d  = (state_d == DUP);
        qed_ready_d = (state_d != DUP) && (occ_d == CNT_ZERO);

        if (bus.qic_vld != (ins | del)) begin
            sync_err_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            occ_q       <= CNT_ZERO;
            burst_q     <= CNT_ZERO;
            exec_dup_q  <= 1'b0;
            qed_ready_q <= 1'b1;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            burst_q     <= burst_d;
            exec_dup_q  <= exec_dup_d;
            qed_ready_q <= qed_ready_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign bus.exec_dup  = exec_dup_q;
    assign bus.ifu_hold  = exec_dup_q;
    assign bus.occ_cnt   = occ_q;
    assign bus.qed_ready = qed_ready_q;
    assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_qed_mode_ctrl.sv
// Directed bench for qed_mode_ctrl: one instance with default parameters and
// one with MAX_BURST = 31 so the queue-full switch can be exercised.
module tb_qed_mode_ctrl;

    localparam int unsigned CNT_W = 5;
    localparam logic [31:0] ADDI  = 32'h0000_0013;
    localparam logic [31:0] NOP   = 32'h0000_007F;

    logic clk = 1'b0;
    logic rst;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qed_mode_ctrl_if #(.CNT_W(CNT_W)) b1 ();
    qed_mode_ctrl_if #(.CNT_W(CNT_W)) b2 ();

    qed_mode_ctrl #(.ICACHESIZE(32), .CNT_W(CNT_W), .MAX_BURST(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.master)
    );

    qed_mode_ctrl #(.ICACHESIZE(32), .CNT_W(CNT_W), .MAX_BURST(31)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic st1(input string tag, input logic dup, input int occ,
                       input logic rdy, input logic err);
        chk({tag, ".exec_dup"},  32'(b1.exec_dup),  32'(dup));
        chk({tag, ".ifu_hold"},  32'(b1.ifu_hold),  32'(dup));
        chk({tag, ".occ_cnt"},   32'(b1.occ_cnt),   32'(occ));
        chk({tag, ".qed_ready"}, 32'(b1.qed_ready), 32'(rdy));
        chk({tag, ".sync_err"},  32'(b1.sync_err),  32'(err));
    endtask

    task automatic st2(input string tag, input logic dup, input int occ,
                       input logic rdy, input logic err);
        chk({tag, ".exec_dup"},  32'(b2.exec_dup),  32'(dup));
        chk({tag, ".ifu_hold"},  32'(b2.ifu_hold),  32'(dup));
        chk({tag, ".occ_cnt"},   32'(b2.occ_cnt),   32'(occ));
        chk({tag, ".qed_ready"}, 32'(b2.qed_ready), 32'(rdy));
        chk({tag, ".sync_err"},  32'(b2.sync_err),  32'(err));
    endtask

    task automatic drv1(input logic ena, input logic stall, input logic [31:0] instr,
                        input logic vld);
        b1.qed_ena             = ena;
        b1.IF_stall            = stall;
        b1.ifu_qed_instruction = instr;
        b1.qic_vld             = vld;
        tick();
    endtask

    task automatic drv2(input logic ena, input logic stall, input logic [31:0] instr,
                        input logic vld);
        b2.qed_ena             = ena;
        b2.IF_stall            = stall;
        b2.ifu_qed_instruction = instr;
        b2.qic_vld             = vld;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        b1.qed_ena = 1'b0; b1.IF_stall = 1'b0; b1.ifu_qed_instruction = ADDI; b1.qic_vld = 1'b0;
        b2.qed_ena = 1'b0; b2.IF_stall = 1'b0; b2.ifu_qed_instruction = ADDI; b2.qic_vld = 1'b0;
        tick();
        tick();
        st1("reset", 1'b0, 0, 1'b1, 1'b0);
        st2("reset2", 1'b0, 0, 1'b1, 1'b0);
        rst = 1'b1;

        // Plain 16-instruction burst, then a full drain.
        drv1(1'b1, 1'b0, ADDI, 1'b0);
        st1("t1_enter", 1'b0, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t1_ins%0d", i), (i == 16), i, 1'b0, 1'b0);
        end
        for (int j = 1; j <= 16; j++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t1_del%0d", j), (j != 16), 16 - j, (j == 16), 1'b0);
        end
        drv1(1'b0, 1'b0, NOP, 1'b0);
        st1("t1_idle", 1'b0, 0, 1'b1, 1'b0);

        // Nops interleaved with ADDIs; drain with qed_ena low.
        drv1(1'b1, 1'b0, NOP, 1'b0);
        st1("t2_enter", 1'b0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0) drv1(1'b1, 1'b0, NOP, 1'b0);
            else            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t2_w%0d", k), (k == 31), (k + 1) / 2, (k == 0), 1'b0);
        end
        for (int j = 1; j <= 16; j++) begin
            drv1(1'b0, 1'b0, ADDI, 1'b1);
            st1($sformatf("t2_del%0d", j), (j != 16), 16 - j, (j == 16), 1'b0);
        end

        // Stalls in the middle of an original and a duplicate burst.
        drv1(1'b1, 1'b0, ADDI, 1'b0);
        st1("t4_enter", 1'b0, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t4_ins%0d", i), 1'b0, i, 1'b0, 1'b0);
        end
        for (int s = 0; s < 3; s++) begin
            drv1(1'b1, 1'b1, ADDI, 1'b0);
            st1($sformatf("t4_ostall%0d", s), 1'b0, 5, 1'b0, 1'b0);
        end
        for (int i = 6; i <= 16; i++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t4_ins%0d", i), (i == 16), i, 1'b0, 1'b0);
        end
        for (int j = 1; j <= 4; j++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t4_del%0d", j), 1'b1, 16 - j, 1'b0, 1'b0);
        end
        for (int s = 0; s < 3; s++) begin
            drv1(1'b1, 1'b1, ADDI, 1'b0);
            st1($sformatf("t4_dstall%0d", s), 1'b1, 12, 1'b0, 1'b0);
        end
        for (int j = 5; j <= 16; j++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t4_del%0d", j), (j != 16), 16 - j, (j == 16), 1'b0);
        end

        // qed_ena dropped at occupancy 5 while in ORIG.
        for (int i = 1; i <= 5; i++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t5_ins%0d", i), 1'b0, i, 1'b0, 1'b0);
        end
        drv1(1'b0, 1'b0, NOP, 1'b0);
        st1("t5_to_dup", 1'b1, 5, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) begin
            drv1(1'b0, 1'b0, ADDI, 1'b1);
            st1($sformatf("t5_del%0d", j), (j != 5), 5 - j, (j == 5), 1'b0);
        end
        drv1(1'b0, 1'b0, ADDI, 1'b0);
        st1("t5_idle", 1'b0, 0, 1'b1, 1'b0);

        // Missing vld on a counted insert, then reset mid-drain.
        drv1(1'b1, 1'b0, ADDI, 1'b0);
        st1("t6_enter", 1'b0, 0, 1'b1, 1'b0);
        drv1(1'b1, 1'b0, ADDI, 1'b0);
        st1("t6_mismatch", 1'b0, 1, 1'b0, 1'b1);
        for (int i = 2; i <= 16; i++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t6_ins%0d", i), (i == 16), i, 1'b0, 1'b1);
        end
        for (int j = 1; j <= 9; j++) begin
            drv1(1'b1, 1'b0, ADDI, 1'b1);
            st1($sformatf("t6_del%0d", j), 1'b1, 16 - j, 1'b0, 1'b1);
        end
        rst = 1'b0;
        drv1(1'b1, 1'b0, ADDI, 1'b1);
        st1("t6_reset", 1'b0, 0, 1'b1, 1'b0);
        rst = 1'b1;
        drv1(1'b0, 1'b0, ADDI, 1'b0);
        st1("t6_after", 1'b0, 0, 1'b1, 1'b0);

        // Queue-full switch with MAX_BURST = 31, 40 valid instructions offered.
        drv2(1'b1, 1'b0, ADDI, 1'b0);
        st2("t3_enter", 1'b0, 0, 1'b1, 1'b0);
        for (int i = 1; i <= 31; i++) begin
            drv2(1'b1, 1'b0, ADDI, 1'b1);
            st2($sformatf("t3_ins%0d", i), (i == 31), i, 1'b0, 1'b0);
        end
        for (int j = 1; j <= 9; j++) begin
            drv2(1'b1, 1'b0, ADDI, 1'b1);
            st2($sformatf("t3_del%0d", j), 1'b1, 31 - j, 1'b0, 1'b0);
        end
        for (int j = 10; j <= 31; j++) begin
            drv2(1'b0, 1'b0, ADDI, 1'b1);
            st2($sformatf("t3_del%0d", j), (j != 31), 31 - j, (j == 31), 1'b0);
        end
        st1("t3_dut1_quiet", 1'b0, 0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
